// File: rtl/instr_fetch.sv
// Program-counter / fetch sequencer for the 512-entry instruction ROM.
// Tracks IDLE/RUN/DONE, applies branches and halts, and counts retired instructions.
module instr_fetch #(
    parameter int PC_W  = 9,
    parameter int OFF_W = 15,
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Stall,
    input  logic             Halt,
    input  logic             BranchTaken,
    input  logic [OFF_W-1:0] BranchOff,
    output logic [PC_W-1:0]  Iptr,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCount,
    output logic             PcWrap
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [PC_W-1:0]  r_pc, w_pc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_wrap, w_wrap_nxt;
    logic [OFF_W:0]   w_off_ext, w_br_sum;

    // Branch target is formed at OFF_W+1 bits; only the low PC_W bits address the ROM.
    assign w_off_ext = {BranchOff[OFF_W-1], BranchOff};
    assign w_br_sum  = {{(OFF_W+1-PC_W){1'b0}}, r_pc} + w_off_ext;
    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_wrap_nxt  = r_wrap;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = StartAddr;
                    w_cnt_nxt   = '0;
                    w_wrap_nxt  = 1'b0;
                end
            end
            S_RUN: begin
                if (!Stall) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (Halt) begin
                        w_state_nxt = S_DONE;
                    end else if (BranchTaken) begin
                        w_pc_nxt = w_br_sum[PC_W-1:0];
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                        if (r_pc == {PC_W{1'b1}}) w_wrap_nxt = 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_cnt   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign Iptr       = r_pc;
    assign InstrCount = r_cnt;
    assign PcWrap     = r_wrap;
    assign Running    = (r_state == S_RUN);
    assign Done       = (r_state == S_DONE);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: sequencing, branches, stall, halt, wrap and reset.
module tb_instr_fetch;

    logic        Clk = 1'b0;
    logic        Reset, Start, Stall, Halt, BranchTaken;
    logic [8:0]  StartAddr;
    logic [14:0] BranchOff;
    logic [8:0]  Iptr;
    logic        Running, Done, PcWrap;
    logic [15:0] InstrCount;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Stall(Stall), .Halt(Halt), .BranchTaken(BranchTaken), .BranchOff(BranchOff),
        .Iptr(Iptr), .Running(Running), .Done(Done), .InstrCount(InstrCount),
        .PcWrap(PcWrap)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] pc, input logic [15:0] cnt,
                           input logic run, input logic dn, input logic wr);
        chk({tag, ".iptr"}, {23'd0, Iptr}, {23'd0, pc});
        chk({tag, ".cnt"}, {16'd0, InstrCount}, {16'd0, cnt});
        chk({tag, ".run"}, {31'd0, Running}, {31'd0, run});
        chk({tag, ".done"}, {31'd0, Done}, {31'd0, dn});
        chk({tag, ".wrap"}, {31'd0, PcWrap}, {31'd0, wr});
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; StartAddr = '0; Stall = 1'b0;
        Halt = 1'b0; BranchTaken = 1'b0; BranchOff = '0;
        tick(); tick();
        chk_all("reset", 9'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        Reset = 1'b0;
        tick();
        chk_all("idle_hold", 9'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        // Sequential run from 1
        Start = 1'b1; StartAddr = 9'd1;
        tick();
        Start = 1'b0;
        chk_all("start1", 9'd1, 16'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 2; i <= 6; i++) begin
            tick();
            chk("seq.iptr", {23'd0, Iptr}, i);
        end
        chk_all("seq_end", 9'd6, 16'd5, 1'b1, 1'b0, 1'b0);

        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        chk_all("halt1", 9'd6, 16'd6, 1'b0, 1'b1, 1'b0);

        // Branches
        Start = 1'b1; StartAddr = 9'd16;
        tick();
        Start = 1'b0;
        chk_all("start16", 9'd16, 16'd0, 1'b1, 1'b0, 1'b0);
        BranchTaken = 1'b1; BranchOff = 15'h7FF3;
        tick();
        chk_all("br_back", 9'd3, 16'd1, 1'b1, 1'b0, 1'b0);
        BranchTaken = 1'b0;
        tick(); tick();
        chk_all("to5", 9'd5, 16'd3, 1'b1, 1'b0, 1'b0);
        BranchTaken = 1'b1; BranchOff = 15'd4;
        tick();
        chk_all("br_fwd", 9'd9, 16'd4, 1'b1, 1'b0, 1'b0);
        BranchOff = 15'h7FFE;
        tick();
        chk_all("br_m2", 9'd7, 16'd5, 1'b1, 1'b0, 1'b0);

        // Stall with a pending branch
        Stall = 1'b1; BranchOff = 15'd4;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_all("stall", 9'd7, 16'd5, 1'b1, 1'b0, 1'b0);
        end
        Stall = 1'b0;
        tick();
        chk_all("stall_rel", 9'd11, 16'd6, 1'b1, 1'b0, 1'b0);

        // Halt beats branch
        BranchOff = 15'd48;
        tick();
        chk_all("to3b", 9'h3B, 16'd7, 1'b1, 1'b0, 1'b0);
        Halt = 1'b1; BranchOff = 15'd4;
        tick();
        Halt = 1'b0; BranchTaken = 1'b0;
        chk_all("halt_br", 9'h3B, 16'd8, 1'b0, 1'b1, 1'b0);
        tick();
        chk_all("done_hold", 9'h3B, 16'd8, 1'b0, 1'b1, 1'b0);
        Start = 1'b1; StartAddr = 9'h19;
        tick();
        Start = 1'b0;
        chk_all("restart", 9'h19, 16'd0, 1'b1, 1'b0, 1'b0);

        // PC wrap
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        Start = 1'b1; StartAddr = 9'd510;
        tick();
        Start = 1'b0;
        chk_all("w510", 9'd510, 16'd0, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("w511", 9'd511, 16'd1, 1'b1, 1'b0, 1'b0);
        tick();
        chk_all("w0", 9'd0, 16'd2, 1'b1, 1'b0, 1'b1);
        tick();
        chk_all("w1", 9'd1, 16'd3, 1'b1, 1'b0, 1'b1);
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        chk_all("w_halt", 9'd1, 16'd4, 1'b0, 1'b1, 1'b1);
        Start = 1'b1; StartAddr = 9'd1;
        tick();
        Start = 1'b0;
        chk_all("w_clear", 9'd1, 16'd0, 1'b1, 1'b0, 1'b0);

        // Start ignored in RUN, then reset mid-run
        BranchTaken = 1'b1; BranchOff = 15'd40;
        tick();
        BranchTaken = 1'b0;
        chk_all("to29", 9'h29, 16'd1, 1'b1, 1'b0, 1'b0);
        Start = 1'b1; StartAddr = 9'h100;
        tick();
        Start = 1'b0;
        chk_all("start_in_run", 9'h2A, 16'd2, 1'b1, 1'b0, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk_all("mid_reset", 9'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("post_reset", 9'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
